ddc_edid_responder: RTL and testbench
=====================================

# ddc_edid_responder

I2C slave (responder) that serves a 256-byte EDID image to a monitor-side or source-side DDC master at device address 0xA0/0xA1, the opposite end of the I2C master the system uses for TVP7002/HDMI TX configuration. It oversamples SCL/SDA on the 50 MHz system clock, decodes START/STOP, address, offset-write and sequential-read transactions, and fetches bytes from an external synchronous EDID ROM. It sits at the VGA/HDMI output connector's DDC pins, beside the output path of the scaler.

## Interface
- DEV_ADDR, 7'h50, 7-bit I2C address responded to.
- FILTER_LEN, 3, consecutive identical synchronized samples required to accept a new SCL/SDA level (1-7).
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- rom_addr  out  8  EDID ROM address, equals current offset register.
- rom_data  in  8  ROM read data, valid one clk50 after rom_addr changes.
- busy  out  1  high from address match until STOP, repeated START or read NACK.

## Operation
- Input path: 2-FF synchronizer per line, then glitch filter (level changes only after FILTER_LEN equal samples). Edges/conditions derived from filtered levels only.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both honoured in every state; START -> ADDR, STOP -> IDLE. sda_oe cleared on either.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shift SDA on 8 SCL rising edges (MSB first). On 8th bit: address match -> at next SCL falling edge set sda_oe=1, busy=1, enter ADDR_ACK; mismatch -> IGNORE (sda_oe stays 0 until START/STOP).
- ADDR_ACK: at next SCL falling edge: R/W=0 -> release SDA, WR_BYTE; R/W=1 -> load shift register from rom_data, sda_oe = ~bit7, RD_BYTE.
- WR_BYTE: shift 8 bits on rising edges; at following falling edge drive ACK, WR_ACK. First data byte after address sets offset; later bytes in same transaction are ACKed and discarded (ROM is read-only). WR_ACK: release at next falling edge, back to WR_BYTE.
- RD_BYTE: on each SCL falling edge shift and drive next bit (sda_oe = ~bit). At 8th falling edge release SDA, offset <= offset+1 (8-bit wrap 0xFF -> 0x00), enter RD_ACK.
- RD_ACK: sample SDA on SCL rising edge. 0 (ACK) -> at next falling edge load rom_data, drive MSB, RD_BYTE. 1 (NACK) -> busy=0, IGNORE.
- Offset persists across transactions; only reset clears it. Current-address read (no offset write) starts at stored offset.
- No clock stretching; sda_oe never asserted in IDLE/IGNORE.

## Timing
- Reset values: sda_oe=0, busy=0, rom_addr=0x00, state IDLE.
- Detection latency from pin to filtered level: 2 + FILTER_LEN clk50 cycles.
- sda_oe changes exactly 1 clk50 after the filtered SCL falling edge is detected; never while filtered SCL is high, except clearing on START/STOP.
- rom_addr updates 1 clk50 after the 8th falling edge; rom_data consumed at next falling edge, ≥ SCL high+low time later.
- Supported SCL: high and low phases each ≥ 2·(2+FILTER_LEN)+2 clk50 cycles (≤ 400 kHz at 50 MHz comfortably).
- Simultaneous START detection and any bit event: START wins. Reset mid-transaction: returns to IDLE next cycle, SDA released.

## Test plan
- Reset with SCL/SDA high -> sda_oe=0, busy=0, rom_addr=0x00 held for 100 cycles.
- START, 0xA0, 0x10, repeated START, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP with ROM[n]=n^0x5A -> ACK on addr/offset/addr, data 0x4A,0x4B,0x48, rom_addr=0x13 after, busy low after NACK.
- START, 0xA2 (wrong address), 8 clocks -> sda_oe never asserted, busy=0, offset unchanged.
- Offset 0xFE, read 3 bytes -> data ROM[0xFE],ROM[0xFF],ROM[0x00]; rom_addr wraps to 0x01.
- 1-cycle SDA glitch during SCL high with FILTER_LEN=3 -> no START/STOP detected, transfer completes correctly.
- STOP asserted mid RD_BYTE (after bit 4) -> sda_oe=0 within 2+FILTER_LEN+1 cycles, state IDLE; next current-address read starts at incremented-or-not offset as specified (unchanged, since byte incomplete).

Source files
------------

// File: rtl/ddc_edid_responder.sv
// DDC/EDID I2C responder: oversamples SCL/SDA, decodes address, offset write and
// sequential reads, and serves bytes from an external synchronous 256-byte EDID ROM.
module ddc_edid_responder #(
    parameter logic [6:0]  DEV_ADDR   = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       busy
);

    localparam logic [2:0] FiltMax = 3'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StIgnore
    } state_e;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic [2:0] scl_cnt_q, sda_cnt_q;
    logic       scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

    state_e     state_q;
    logic [7:0] shift_q;
    logic [7:0] offset_q;
    logic [3:0] bit_cnt_q;
    logic       rw_q, first_q, acked_q;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Filtered level follows the synchronized input only after FILTER_LEN equal samples.
    always_ff @(posedge clk50) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FiltMax) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + 3'd1;
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FiltMax) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + 3'd1;
            end
            scl_prev_q <= scl_f_q;
            sda_prev_q <= sda_f_q;
        end
    end

    assign scl_rise  = scl_f_q & ~scl_prev_q;
    assign scl_fall  = ~scl_f_q & scl_prev_q;
    assign start_det = scl_f_q & scl_prev_q & ~sda_f_q & sda_prev_q;
    assign stop_det  = scl_f_q & scl_prev_q & sda_f_q & ~sda_prev_q;
    assign rom_addr  = offset_q;

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q   <= StIdle;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            offset_q  <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            acked_q   <= 1'b0;
        end else if (start_det) begin
            state_q   <= StAddr;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            bit_cnt_q <= '0;
            first_q   <= 1'b1;
        end else if (stop_det) begin
            state_q <= StIdle;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StWrByte: begin
                    if (scl_rise) begin
                        shift_q   <= {shift_q[6:0], sda_f_q};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == StWrByte) begin
                            sda_oe  <= 1'b1;
                            state_q <= StWrAck;
                            // Only the first data byte is an offset; the ROM is read-only.
                            if (first_q) begin
                                offset_q <= shift_q;
                                first_q  <= 1'b0;
                            end
                        end else if (shift_q[7:1] == DEV_ADDR) begin
                            sda_oe  <= 1'b1;
                            busy    <= 1'b1;
                            rw_q    <= shift_q[0];
                            state_q <= StAddrAck;
                        end else begin
                            state_q <= StIgnore;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_q <= '0;
                        if (rw_q) begin
                            shift_q <= rom_data;
                            sda_oe  <= ~rom_data[7];
                            state_q <= StRdByte;
                        end else begin
                            sda_oe  <= 1'b0;
                            state_q <= StWrByte;
                        end
                    end
                end
                StWrAck: begin
                    if (scl_fall) begin
                        sda_oe    <= 1'b0;
                        bit_cnt_q <= '0;
                        state_q   <= StWrByte;
                    end
                end
                StRdByte: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe   <= 1'b0;
                            offset_q <= offset_q + 8'd1;
                            acked_q  <= 1'b0;
                            state_q  <= StRdAck;
                        end else begin
                            shift_q   <= {shift_q[6:0], 1'b0};
                            sda_oe    <= ~shift_q[6];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_f_q) begin
                            busy    <= 1'b0;
                            state_q <= StIgnore;
                        end else begin
                            acked_q <= 1'b1;
                        end
                    end else if (scl_fall && acked_q) begin
                        shift_q   <= rom_data;
                        sda_oe    <= ~rom_data[7];
                        bit_cnt_q <= '0;
                        state_q   <= StRdByte;
                    end
                end
                StIdle, StIgnore: begin
                    sda_oe <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    sda_oe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddc_edid_responder.sv
// Directed bench for ddc_edid_responder: bit-banged I2C master on a wired-AND SDA line,
// ROM model ROM[n] = n ^ 0x5A, expected bytes/acks queued and checked on arrival.
module tb_ddc_edid_responder;

    localparam int unsigned FILT = 3;
    localparam int HALF = 10;

    logic       clk50 = 1'b0;
    logic       reset;
    logic       master_scl, master_sda, glitch;
    logic       scl_in, sda_in, sda_oe, busy;
    logic [7:0] rom_addr, rom_data;

    int n_cmp = 0;
    int n_err = 0;
    int unsigned oe_cnt = 0;
    bit glitch_arm;
    logic [7:0] exp_q[$];

    always #10 clk50 = ~clk50;

    assign scl_in = master_scl;
    assign sda_in = (master_sda & ~sda_oe) ^ glitch;

    always @(posedge clk50) rom_data <= rom_addr ^ 8'h5A;
    always @(posedge clk50) if (sda_oe) oe_cnt <= oe_cnt + 1;

    ddc_edid_responder #(
        .DEV_ADDR  (7'h50),
        .FILTER_LEN(FILT)
    ) dut (
        .clk50   (clk50),
        .reset   (reset),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .sda_oe  (sda_oe),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .busy    (busy)
    );

    initial begin
        #4000000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic sb_check(input string tag, input logic [7:0] obs);
        logic [7:0] expv;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %h expected <nothing queued>", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            check(tag, {8'd0, obs}, {8'd0, expv});
        end
    endtask

    task automatic clk_bit(input logic tx, output logic rx);
        cyc(HALF);
        master_sda = tx;
        cyc(HALF);
        master_scl = 1'b1;
        if (glitch_arm) begin
            cyc(4);
            glitch = 1'b1;
            cyc(1);
            glitch = 1'b0;
            cyc(HALF - 5);
            glitch_arm = 1'b0;
        end else begin
            cyc(HALF);
        end
        rx = sda_in;
        cyc(HALF);
        master_scl = 1'b0;
    endtask

    task automatic i2c_start();
        cyc(HALF);
        master_sda = 1'b1;
        cyc(HALF);
        master_scl = 1'b1;
        cyc(2 * HALF);
        master_sda = 1'b0;
        cyc(2 * HALF);
        master_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(HALF);
        master_sda = 1'b0;
        cyc(HALF);
        master_scl = 1'b1;
        cyc(2 * HALF);
        master_sda = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic write_byte(input logic [7:0] b, input string tag);
        logic rx;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], rx);
        clk_bit(1'b1, rx);
        sb_check(tag, {7'd0, rx});
    endtask

    task automatic read_byte(input logic nack, input string tag);
        logic       rx;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, rx);
            d[i] = rx;
        end
        clk_bit(nack, rx);
        sb_check(tag, d);
    endtask

    initial begin
        logic        rx;
        logic [3:0]  nib;
        int unsigned oe_before;

        reset      = 1'b1;
        master_scl = 1'b1;
        master_sda = 1'b1;
        glitch     = 1'b0;
        glitch_arm = 1'b0;
        cyc(5);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            check("reset_idle", {6'd0, sda_oe, busy, rom_addr}, 16'h0000);
        end

        // Offset write 0x10, repeated START, read three bytes
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA0, "t2_addr_w_ack");
        exp_q.push_back(8'h00); write_byte(8'h10, "t2_offset_ack");
        check("t2_offset_set", {8'd0, rom_addr}, 16'h0010);
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA1, "t2_addr_r_ack");
        check("t2_busy_high", {15'd0, busy}, 16'h0001);
        exp_q.push_back(8'h4A); read_byte(1'b0, "t2_rd0");
        exp_q.push_back(8'h4B); read_byte(1'b0, "t2_rd1");
        exp_q.push_back(8'h48); read_byte(1'b1, "t2_rd2");
        check("t2_busy_after_nack", {15'd0, busy}, 16'h0000);
        i2c_stop();
        check("t2_rom_addr_end", {8'd0, rom_addr}, 16'h0013);

        // Wrong device address is ignored
        oe_before = oe_cnt;
        i2c_start();
        exp_q.push_back(8'h01); write_byte(8'hA2, "t3_addr_nack");
        check("t3_oe_never", 16'(oe_cnt - oe_before), 16'h0000);
        check("t3_busy_low", {15'd0, busy}, 16'h0000);
        check("t3_offset_kept", {8'd0, rom_addr}, 16'h0013);
        i2c_stop();

        // Offset wrap 0xFF -> 0x00
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA0, "t4_addr_w_ack");
        exp_q.push_back(8'h00); write_byte(8'hFE, "t4_offset_ack");
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA1, "t4_addr_r_ack");
        exp_q.push_back(8'hA4); read_byte(1'b0, "t4_rd_fe");
        exp_q.push_back(8'hA5); read_byte(1'b0, "t4_rd_ff");
        exp_q.push_back(8'h5A); read_byte(1'b1, "t4_rd_00");
        i2c_stop();
        check("t4_rom_addr_wrap", {8'd0, rom_addr}, 16'h0001);

        // One-cycle SDA glitches while SCL is high must be filtered out
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA0, "t5_addr_w_ack");
        glitch_arm = 1'b1;
        exp_q.push_back(8'h00); write_byte(8'h20, "t5_offset_ack_glitch");
        check("t5_offset_set", {8'd0, rom_addr}, 16'h0020);
        i2c_start();
        glitch_arm = 1'b1;
        exp_q.push_back(8'h00); write_byte(8'hA1, "t5_addr_r_ack_glitch");
        exp_q.push_back(8'h7A); read_byte(1'b1, "t5_rd_20");
        i2c_stop();
        check("t5_rom_addr_end", {8'd0, rom_addr}, 16'h0021);

        // STOP in the middle of a read byte; offset must not advance
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA1, "t6_addr_r_ack");
        exp_q.push_back(8'h07);
        for (int i = 3; i >= 0; i--) begin
            clk_bit(1'b1, rx);
            nib[i] = rx;
        end
        sb_check("t6_partial_bits", {4'd0, nib});
        check("t6_busy_mid", {15'd0, busy}, 16'h0001);
        cyc(HALF);
        master_sda = 1'b0;
        cyc(HALF);
        master_scl = 1'b1;
        cyc(2 * HALF);
        master_sda = 1'b1;
        cyc(2 + FILT + 1);
        check("t6_stop_release", {14'd0, sda_oe, busy}, 16'h0000);
        check("t6_offset_kept", {8'd0, rom_addr}, 16'h0021);
        cyc(2 * HALF);
        i2c_start();
        exp_q.push_back(8'h00); write_byte(8'hA1, "t6_cur_addr_ack");
        exp_q.push_back(8'h7B); read_byte(1'b1, "t6_cur_rd_21");
        i2c_stop();
        check("t6_rom_addr_end", {8'd0, rom_addr}, 16'h0022);
        check("t6_queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
